program_loader: RTL

- Responder side of the boot-load handshake: serves the level requests transmit_0x99 / receive_program_data_size / receive_program_data / transmit_0xAA from the state controller and answers each with a *_finished level.
- Sends the handshake bytes 0x99 and 0xAA over the UART TX byte interface.
- Assembles the UART RX byte stream into the program size and program words, and writes the words into instruction memory.
- Sits between the UART byte layer, the state controller and the instruction RAM write port.

---
 rtl/program_loader.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot-load responder: sends handshake bytes, receives program size and words into IMEM.
// Optional trailing XOR checksum byte on the data phase: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned IMEM_ADDR_WIDTH = 15,
    parameter logic [7:0]  BYTE_TX_99      = 8'h99,
    parameter logic [7:0]  BYTE_TX_AA      = 8'hAA
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       transmit_0x99,
    input  logic                       receive_program_data_size,
    input  logic                       receive_program_data,
    input  logic                       transmit_0xAA,
    output logic                       transmit_0x99_finished,
    output logic                       receive_program_data_size_finished,
    output logic                       receive_program_data_finished,
    output logic                       transmit_0xAA_finished,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_data,
    output logic                       imem_write_enable,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [31:0]                program_size,
    output logic                       size_overflow,
    output logic                       checksum_error
);

    localparam logic [32:0] DEPTH = 33'd1 << IMEM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_SIZE,
        S_DATA,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_99,
        PH_SIZE,
        PH_DATA,
        PH_AA
    } phase_t;

    state_t                     state_q, state_d;
    phase_t                     phase_q, phase_d;
    logic                       tx_valid_q, tx_valid_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic [1:0]                 byte_cnt_q, byte_cnt_d;
    logic [31:0]                word_cnt_q, word_cnt_d;
    logic [31:0]                asm_q, asm_d;
    logic [31:0]                size_q, size_d;
    logic                       ovf_q, ovf_d;
    logic                       we_q, we_d;
    logic [IMEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       req_cur;
    logic [31:0]                asm_ins;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]                 csum_q, csum_d;
    logic                       cerr_q, cerr_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_99;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            asm_q      <= '0;
            size_q     <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            cerr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            asm_q      <= asm_d;
            size_q     <= size_d;
            ovf_q      <= ovf_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            cerr_q     <= cerr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_d      = asm_q;
        size_d     = size_q;
        ovf_d      = ovf_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        cerr_d     = cerr_q;
`endif
        asm_ins = asm_q;
        asm_ins[{byte_cnt_q, 3'b000} +: 8] = rx_data;

        unique case (phase_q)
            PH_99:   req_cur = transmit_0x99;
            PH_SIZE: req_cur = receive_program_data_size;
            PH_DATA: req_cur = receive_program_data;
            PH_AA:   req_cur = transmit_0xAA;
            default: req_cur = 1'b0;
        endcase

        unique case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                asm_d      = '0;
                if (transmit_0x99) begin
                    phase_d    = PH_99;
                    state_d    = S_TX;
                    tx_valid_d = 1'b1;
                    tx_data_d  = BYTE_TX_99;
                end else if (receive_program_data_size) begin
                    phase_d = PH_SIZE;
                    state_d = S_SIZE;
                end else if (receive_program_data) begin
                    phase_d    = PH_DATA;
                    state_d    = S_DATA;
                    word_cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
                    cerr_d     = 1'b0;
`endif
                end else if (transmit_0xAA) begin
                    phase_d    = PH_AA;
                    state_d    = S_TX;
                    tx_valid_d = 1'b1;
                    tx_data_d  = BYTE_TX_AA;
                end
            end
            S_TX: begin
                if (!req_cur) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                end else if (tx_ready) begin
                    state_d    = S_DONE;
                    tx_valid_d = 1'b0;
                end
            end
            S_SIZE: begin
                if (!req_cur) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    asm_d      = asm_ins;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        size_d  = asm_ins;
                        ovf_d   = {1'b0, asm_ins} > DEPTH;
                        state_d = S_DONE;
                    end
                end
            end
            S_DATA: begin
                if (!req_cur) begin
                    state_d = S_IDLE;
                end else if (word_cnt_q == size_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    // Trailing byte after the last word carries the XOR of all data bytes
                    if (rx_valid) begin
                        cerr_d  = rx_data != csum_q;
                        state_d = S_DONE;
                    end
`else
                    state_d = S_DONE;
`endif
                end else if (rx_valid) begin
                    asm_d      = asm_ins;
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = {1'b0, word_cnt_q} < DEPTH;
                        waddr_d    = word_cnt_q[IMEM_ADDR_WIDTH-1:0];
                        wdata_d    = asm_ins;
                        word_cnt_d = word_cnt_q + 32'd1;
                    end
                end
            end
            S_DONE: begin
                if (!req_cur) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign transmit_0x99_finished             = (state_q == S_DONE) && (phase_q == PH_99);
    assign receive_program_data_size_finished = (state_q == S_DONE) && (phase_q == PH_SIZE);
    assign receive_program_data_finished      = (state_q == S_DONE) && (phase_q == PH_DATA);
    assign transmit_0xAA_finished             = (state_q == S_DONE) && (phase_q == PH_AA);

    assign tx_valid          = tx_valid_q;
    assign tx_data           = tx_data_q;
    assign imem_write_enable = we_q;
    assign imem_addr         = waddr_q;
    assign imem_wdata        = wdata_q;
    assign program_size      = size_q;
    assign size_overflow     = ovf_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign checksum_error    = cerr_q;
`else
    assign checksum_error    = 1'b0;
`endif

endmodule
